// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns one core request at a time into a single-beat AXI read or write.
// Every output comes straight from a flop, so no valid depends combinationally on a ready.
module axi_lite_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_wen_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [DATA_W-1:0]   resp_rdata_o,
    output logic                resp_err_o,
    output logic                mst_ar_valid_o,
    output logic [ADDR_W-1:0]   mst_ar_addr_o,
    input  logic                mst_ar_ready_i,
    input  logic                mst_r_valid_i,
    input  logic [DATA_W-1:0]   mst_r_data_i,
    input  logic [1:0]          mst_r_resp_i,
    output logic                mst_r_ready_o,
    output logic                mst_aw_valid_o,
    output logic [ADDR_W-1:0]   mst_aw_addr_o,
    input  logic                mst_aw_ready_i,
    output logic                mst_w_valid_o,
    output logic [DATA_W-1:0]   mst_w_data_o,
    output logic [DATA_W/8-1:0] mst_w_strb_o,
    input  logic                mst_w_ready_i,
    input  logic                mst_b_valid_i,
    input  logic [1:0]          mst_b_resp_i,
    output logic                mst_b_ready_o
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        RD_ADDR  = 6'b000010,
        RD_DATA  = 6'b000100,
        WR_REQ   = 6'b001000,
        WR_RESP  = 6'b010000,
        CORE_RSP = 6'b100000
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                req_ready_q, req_ready_d;
    logic                ar_valid_q, ar_valid_d;
    logic                r_ready_q, r_ready_d;
    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic                b_ready_q, b_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;

    logic req_hs, ar_hs, r_hs, b_hs, rsp_hs, aw_fin, w_fin;

    assign req_hs = req_valid_i & req_ready_q;
    assign ar_hs  = ar_valid_q & mst_ar_ready_i;
    assign r_hs   = mst_r_valid_i & r_ready_q;
    assign b_hs   = mst_b_valid_i & b_ready_q;
    assign rsp_hs = resp_valid_q & resp_ready_i;
    // A write channel is finished once its valid has dropped or it handshakes this cycle.
    assign aw_fin = ~aw_valid_q | mst_aw_ready_i;
    assign w_fin  = ~w_valid_q | mst_w_ready_i;

    // Next-state, capture registers and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;

        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
                    state_d = req_wen_i ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ar_hs) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (r_hs) begin
                    rdata_d = mst_r_data_i;
                    resp_d  = mst_r_resp_i;
                    state_d = CORE_RSP;
                end
            end
            WR_REQ: begin
                if (aw_fin && w_fin) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) begin
                    rdata_d = '0;
                    resp_d  = mst_b_resp_i;
                    state_d = CORE_RSP;
                end
            end
            CORE_RSP: begin
                if (rsp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        ar_valid_d   = (state_d == RD_ADDR);
        r_ready_d    = (state_d == RD_DATA);
        b_ready_d    = (state_d == WR_RESP);
        resp_valid_d = (state_d == CORE_RSP);
        resp_err_d   = (state_d == CORE_RSP) && (resp_d != 2'b00);
        // Both write valids rise on entry; each then falls on its own handshake.
        aw_valid_d   = (state_d == WR_REQ) &&
                       ((state_q != WR_REQ) || (aw_valid_q && !mst_aw_ready_i));
        w_valid_d    = (state_d == WR_REQ) &&
                       ((state_q != WR_REQ) || (w_valid_q && !mst_w_ready_i));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
            req_ready_q  <= 1'b0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            req_ready_q  <= req_ready_d;
            ar_valid_q   <= ar_valid_d;
            r_ready_q    <= r_ready_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            b_ready_q    <= b_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_rdata_o   = rdata_q;
    assign resp_err_o     = resp_err_q;
    assign mst_ar_valid_o = ar_valid_q;
    assign mst_ar_addr_o  = addr_q;
    assign mst_r_ready_o  = r_ready_q;
    assign mst_aw_valid_o = aw_valid_q;
    assign mst_aw_addr_o  = addr_q;
    assign mst_w_valid_o  = w_valid_q;
    assign mst_w_data_o   = wdata_q;
    assign mst_w_strb_o   = wstrb_q;
    assign mst_b_ready_o  = b_ready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-programmable AXI slave and core agent, with a
// timing/data model of each transaction.
module tb_axi_lite_master;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              clk_i;
    logic              rst_i;
    logic              req_valid_i, req_ready_o, req_wen_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic [STRB_W-1:0] req_wstrb_i;
    logic              resp_valid_o, resp_ready_i, resp_err_o;
    logic [DATA_W-1:0] resp_rdata_o;
    logic              mst_ar_valid_o, mst_ar_ready_i;
    logic [ADDR_W-1:0] mst_ar_addr_o;
    logic              mst_r_valid_i, mst_r_ready_o;
    logic [DATA_W-1:0] mst_r_data_i;
    logic [1:0]        mst_r_resp_i;
    logic              mst_aw_valid_o, mst_aw_ready_i;
    logic [ADDR_W-1:0] mst_aw_addr_o;
    logic              mst_w_valid_o, mst_w_ready_i;
    logic [DATA_W-1:0] mst_w_data_o;
    logic [STRB_W-1:0] mst_w_strb_o;
    logic              mst_b_valid_i, mst_b_ready_o;
    logic [1:0]        mst_b_resp_i;

    axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_ready_i(mst_ar_ready_i),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i),
        .mst_r_ready_o(mst_r_ready_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_ready_i(mst_aw_ready_i),
        .mst_w_valid_o(mst_w_valid_o), .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o),
        .mst_w_ready_i(mst_w_ready_i),
        .mst_b_valid_i(mst_b_valid_i), .mst_b_resp_i(mst_b_resp_i), .mst_b_ready_o(mst_b_ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    // da: AR (read) or AW (write) ready delay; dw: W ready delay; drb: R/B valid delay;
    // drsp: core resp_ready delay; hold: keep req_valid high for the whole transaction.
    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          da, dw, drb, drsp;
        logic        hold;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic        err;
        int          n_arv, n_awv, n_wv, n_rhs, n_bhs, n_req, n_respv, n_viol;
        logic        tmo;
    } res_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {24'd0, req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o, mst_ar_valid_o,
                mst_r_ready_o, mst_aw_valid_o, mst_w_valid_o, mst_b_ready_o};
    endfunction

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [31:0] rdata, input logic [1:0] resp,
                                input int da, input int dw, input int drb, input int drsp,
                                input logic hold, input int lat, input logic [31:0] erd,
                                input logic eerr);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.strb = strb; v.rdata = rdata;
        v.resp = resp; v.da = da; v.dw = dw; v.drb = drb; v.drsp = drsp; v.hold = hold;
        v.exp_lat = lat; v.exp_rd = erd; v.exp_err = eerr;
        return v;
    endfunction

    // Reference: the request handshakes in cycle 0 and the response rises three cycles
    // later plus the slave's stalls; writes wait for the slower of AW and W.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        int   addr_stall = v.wen ? ((v.da > v.dw) ? v.da : v.dw) : v.da;
        e.exp_lat = 3 + addr_stall + v.drb;
        e.exp_rd  = v.wen ? 32'd0 : v.rdata;
        e.exp_err = (v.resp != 2'b00);
        return e;
    endfunction

    task automatic clear_inputs();
        req_valid_i = 0; req_wen_i = 0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
        resp_ready_i = 0; mst_ar_ready_i = 0; mst_r_valid_i = 0; mst_r_data_i = '0;
        mst_r_resp_i = 2'b00; mst_aw_ready_i = 0; mst_w_ready_i = 0; mst_b_valid_i = 0;
        mst_b_resp_i = 2'b00;
    endtask

    // Runs one transaction; all driving and sampling happens on the falling edge.
    task automatic txn(input vec_t v, output res_t r);
        bit hs_ar, hs_aw, hs_w, hs_r, hs_b, hs_rsp, hs_req, a_done, w_done, rb_done, got;
        int wa = 0, ww = 0, wrb = 0, wrsp = 0, c0 = 0;
        r = '{lat: -1, rd: '0, err: 1'b0, n_arv: 0, n_awv: 0, n_wv: 0, n_rhs: 0, n_bhs: 0,
              n_req: 0, n_respv: 0, n_viol: 0, tmo: 1'b1};
        a_done = 0; w_done = 0; rb_done = 0; got = 0;
        @(negedge clk_i);
        req_valid_i = 1; req_wen_i = v.wen; req_addr_i = v.addr;
        req_wdata_i = v.wdata; req_wstrb_i = v.strb;
        for (int c = 0; c < 300; c++) begin
            hs_req = req_valid_i && req_ready_o;
            if (hs_req) begin
                r.n_req++;
                if (r.n_req == 1) c0 = cyc;
            end
            if (resp_valid_o && req_ready_o) r.n_viol++;
            if (mst_ar_valid_o) begin
                r.n_arv++;
                if (mst_ar_addr_o !== v.addr) r.n_viol++;
                if (wa >= v.da) mst_ar_ready_i = 1; else wa++;
            end
            if (mst_aw_valid_o) begin
                r.n_awv++;
                if (mst_aw_addr_o !== v.addr) r.n_viol++;
                if (wa >= v.da) mst_aw_ready_i = 1; else wa++;
            end
            if (mst_w_valid_o) begin
                r.n_wv++;
                if (mst_w_data_o !== v.wdata || mst_w_strb_o !== v.strb) r.n_viol++;
                if (ww >= v.dw) mst_w_ready_i = 1; else ww++;
            end
            if (!v.wen && a_done && !rb_done) begin
                if (wrb >= v.drb) begin
                    mst_r_valid_i = 1; mst_r_data_i = v.rdata; mst_r_resp_i = v.resp;
                end else wrb++;
            end
            if (v.wen && a_done && w_done && !rb_done) begin
                if (wrb >= v.drb) begin
                    mst_b_valid_i = 1; mst_b_resp_i = v.resp;
                end else wrb++;
            end
            if (resp_valid_o) begin
                r.n_respv++;
                if (!got) begin
                    got = 1; r.lat = cyc - c0; r.rd = resp_rdata_o; r.err = resp_err_o;
                end
                if (wrsp >= v.drsp) resp_ready_i = 1; else wrsp++;
            end
            hs_ar  = mst_ar_valid_o && mst_ar_ready_i;
            hs_aw  = mst_aw_valid_o && mst_aw_ready_i;
            hs_w   = mst_w_valid_o && mst_w_ready_i;
            hs_r   = mst_r_valid_i && mst_r_ready_o;
            hs_b   = mst_b_valid_i && mst_b_ready_o;
            hs_rsp = resp_valid_o && resp_ready_i;
            @(negedge clk_i);
            if (hs_req && !v.hold) req_valid_i = 0;
            if (hs_ar) begin mst_ar_ready_i = 0; a_done = 1; end
            if (hs_aw) begin mst_aw_ready_i = 0; a_done = 1; end
            if (hs_w)  begin mst_w_ready_i = 0; w_done = 1; end
            if (hs_r)  begin mst_r_valid_i = 0; rb_done = 1; r.n_rhs++; end
            if (hs_b)  begin mst_b_valid_i = 0; rb_done = 1; r.n_bhs++; end
            if (hs_rsp) begin r.tmo = 0; break; end
        end
        clear_inputs();
    endtask

    task automatic run_check(input string tag, input vec_t v);
        res_t r;
        txn(v, r);
        chk({tag, ".timeout"}, 64'(r.tmo), 64'd0);
        chk({tag, ".latency"}, 64'(r.lat), 64'(v.exp_lat));
        chk({tag, ".rdata"}, 64'(r.rd), 64'(v.exp_rd));
        chk({tag, ".err"}, 64'(r.err), 64'(v.exp_err));
        chk({tag, ".ar_valid_cycles"}, 64'(r.n_arv), 64'(v.wen ? 0 : v.da + 1));
        chk({tag, ".aw_valid_cycles"}, 64'(r.n_awv), 64'(v.wen ? v.da + 1 : 0));
        chk({tag, ".w_valid_cycles"}, 64'(r.n_wv), 64'(v.wen ? v.dw + 1 : 0));
        chk({tag, ".r_b_handshakes"}, 64'(r.n_rhs * 16 + r.n_bhs), 64'(v.wen ? 1 : 16));
        chk({tag, ".req_accepts"}, 64'(r.n_req), 64'd1);
        chk({tag, ".resp_valid_cycles"}, 64'(r.n_respv), 64'(v.drsp + 1));
        chk({tag, ".stability"}, 64'(r.n_viol), 64'd0);
        chk({tag, ".idle_after"}, 64'(req_ready_o), 64'd1);
    endtask

    vec_t tbl[9];

    initial begin
        vec_t v;
        clear_inputs();
        rst_i = 0;
        tbl[0] = mk(0, 32'h8000_0004, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 3, 32'hDEAD_BEEF, 0);
        tbl[1] = mk(1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF, 2'b00, 3, 0, 0, 0, 0, 6, 32'h0, 0);
        tbl[2] = mk(1, 32'h0000_0100, 32'hA5A5_0001, 4'hF, 32'h0, 2'b00, 2, 0, 1, 0, 0, 6, 32'h0, 0);
        tbl[3] = mk(1, 32'h0000_0104, 32'hA5A5_0002, 4'h5, 32'h0, 2'b00, 0, 0, 0, 0, 0, 3, 32'h0, 0);
        tbl[4] = mk(1, 32'h0000_0108, 32'hA5A5_0003, 4'h8, 32'h0, 2'b10, 0, 4, 0, 1, 0, 7, 32'h0, 1);
        tbl[5] = mk(0, 32'h4000_0020, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b11, 1, 0, 2, 2, 0, 6, 32'hCAFE_F00D, 1);
        tbl[6] = mk(1, 32'h4000_0024, 32'h0BAD_0BAD, 4'hF, 32'h0, 2'b10, 0, 0, 0, 3, 0, 3, 32'h0, 1);
        tbl[7] = mk(0, 32'h4000_0028, 32'h0, 4'h0, 32'h1111_2222, 2'b01, 0, 0, 0, 0, 0, 3, 32'h1111_2222, 1);
        tbl[8] = mk(0, 32'h4000_002C, 32'h0, 4'h0, 32'h3333_4444, 2'b00, 0, 0, 0, 5, 1, 3, 32'h3333_4444, 0);

        repeat (3) @(negedge clk_i);
        chk("reset.outputs", all_outs(), 64'd0);
        chk("reset.req_ready", 64'(req_ready_o), 64'd0);
        rst_i = 1;
        @(negedge clk_i);
        chk("release.req_ready", 64'(req_ready_o), 64'd1);

        for (int i = 0; i < 9; i++) run_check($sformatf("tbl%0d", i), tbl[i]);

        // Reset pulsed while the read waits in RD_DATA.
        @(negedge clk_i);
        req_valid_i = 1; req_wen_i = 0; req_addr_i = 32'h8000_0040;
        @(negedge clk_i);
        req_valid_i = 0;
        chk("rstmid.ar_valid", 64'(mst_ar_valid_o), 64'd1);
        mst_ar_ready_i = 1;
        @(negedge clk_i);
        mst_ar_ready_i = 0;
        chk("rstmid.r_ready", 64'(mst_r_ready_o), 64'd1);
        #2 rst_i = 0;
        #1 chk("rstmid.async_zero", all_outs(), 64'd0);
        @(negedge clk_i);
        chk("rstmid.held_zero", all_outs(), 64'd0);
        rst_i = 1;
        @(negedge clk_i);
        chk("rstmid.release_ready", 64'(req_ready_o), 64'd1);
        chk("rstmid.no_resp", 64'(resp_valid_o), 64'd0);
        run_check("rstmid.next_read",
                  mk(0, 32'h8000_0044, 32'h0, 4'h0, 32'h5566_7788, 2'b00, 0, 0, 0, 0, 0, 3, 32'h5566_7788, 0));

        for (int i = 0; i < 40; i++) begin
            v = mk(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)),
                   $urandom(), 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 32'h0, 0);
            run_check($sformatf("rnd%0d", i), model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning the AXI and request address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning the data width; the strobe width SHALL be DATA_W/8.
REQ-003 The module SHALL have these ports, one per line, in this order:
  clk_i  in  1  single clock; all state changes on its rising edge
  rst_i  in  1  asynchronous, active-low reset
  req_valid_i  in  1  core request valid
  req_ready_o  out  1  core request accepted
  req_wen_i  in  1  1 = write, 0 = read
  req_addr_i  in  ADDR_W  request address
  req_wdata_i  in  DATA_W  write data
  req_wstrb_i  in  DATA_W/8  write byte strobe
  resp_valid_o  out  1  response valid
  resp_ready_i  in  1  core accepts response
  resp_rdata_o  out  DATA_W  read data; 0 for writes
  resp_err_o  out  1  AXI resp was not OKAY (2'b00)
  mst_ar_valid_o / mst_ar_addr_o / mst_ar_ready_i  out/out/in  1/ADDR_W/1  AR channel
  mst_r_valid_i / mst_r_data_i / mst_r_resp_i / mst_r_ready_o  in/in/in/out  1/DATA_W/2/1  R channel
  mst_aw_valid_o / mst_aw_addr_o / mst_aw_ready_i  out/out/in  1/ADDR_W/1  AW channel
  mst_w_valid_o / mst_w_data_o / mst_w_strb_o / mst_w_ready_i  out/out/out/in  1/DATA_W/DATA_W/8/1  W channel
  mst_b_valid_i / mst_b_resp_i / mst_b_ready_o  in/in/out  1/2/1  B channel

Function
REQ-004 The state machine SHALL have the one-hot states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and CORE_RSP.
REQ-005 A handshake on any channel SHALL occur in the cycle where valid and ready are both 1.
REQ-006 req_ready_o SHALL be 1 only in IDLE.
REQ-007 On a request handshake, the block SHALL latch addr, wdata and wstrb, then go to RD_ADDR if req_wen_i=0 or to WR_REQ if req_wen_i=1.
REQ-008 In RD_ADDR, mst_ar_valid_o SHALL be 1 with the latched address and SHALL stay stable until the AR handshake; the block SHALL then go to RD_DATA.
REQ-009 In RD_DATA, mst_r_ready_o SHALL be 1; on the R handshake the block SHALL latch data and resp and go to CORE_RSP.
REQ-010 On entering WR_REQ, mst_aw_valid_o and mst_w_valid_o SHALL both be 1 in the same cycle.
REQ-011 In WR_REQ, each of mst_aw_valid_o and mst_w_valid_o SHALL drop the cycle after its own handshake, independently of the other; address, data and strobe SHALL stay stable while valid.
REQ-012 When both the AW and W handshakes have completed, in either order or in the same cycle, the block SHALL go to WR_RESP.
REQ-013 In WR_RESP, mst_b_ready_o SHALL be 1; on the B handshake the block SHALL latch resp, clear rdata to 0 and go to CORE_RSP.
REQ-014 In CORE_RSP, resp_valid_o SHALL be 1 and resp_err_o SHALL equal (latched resp != 2'b00); on the resp handshake the block SHALL return to IDLE.
REQ-015 There SHALL be at most one outstanding transaction; req_valid_i SHALL be ignored outside IDLE.
REQ-016 All AXI valid and ready outputs SHALL be 0 in every state other than the ones named in REQ-008 to REQ-013.
REQ-017 Valid outputs SHALL NOT depend combinationally on any AXI ready input.
REQ-018 Minimum latency SHALL be: read, request handshake in cycle 0, AR valid in cycle 1, R handshake in cycle 2, resp_valid_o in cycle 3; write, AW and W valid in cycle 1, B handshake in cycle 2, resp_valid_o in cycle 3.
REQ-019 A SLVERR or DECERR response SHALL still complete the transaction normally, with resp_err_o=1.

Reset
REQ-020 While rst_i=0, asynchronously, the state SHALL be IDLE and all valid, ready, resp_err_o and resp_rdata_o outputs SHALL be 0, except req_ready_o.
REQ-021 req_ready_o SHALL be 0 while rst_i=0 and SHALL be 1 from the first clock after release.
REQ-022 A reset asserted mid-transaction SHALL abandon the transaction immediately; no response SHALL be issued for it.

Verification
REQ-023 Read 0x8000_0004 with a zero-wait slave returning 0xDEADBEEF, OKAY -> AR addr=0x8000_0004; resp_valid_o=1 in cycle 3; rdata=0xDEADBEEF; err=0.
REQ-024 Write 0x8000_0010, data 0x1234_5678, strb 4'b0011, with aw_ready delayed 3 cycles and w_ready immediate -> W drops after cycle 1 and AW stays valid until its handshake; one B accepted; rdata=0; err=0.
REQ-025 W handshake before AW, then same-cycle AW+W on the next write -> exactly one AW and one W per write; no duplicate valid cycle.
REQ-026 Read with random slave delays of 0-15 cycles and resp=2'b10 -> resp_err_o=1; data is passed through; the block returns to IDLE.
REQ-027 resp_ready_i held at 0 for 5 cycles while req_valid_i=1 -> resp_valid_o held, req_ready_o=0, no new AR or AW issued.
REQ-028 rst_i pulsed low during RD_DATA -> all outputs zero immediately; after release the next read completes normally.
